// File: rtl/exec_pkg.sv
// exec_pkg: shared uop encodings, flag bit positions and widths for execute_core
package exec_pkg;
    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam logic [4:0] UOP_AND = 5'h00;
    localparam logic [4:0] UOP_EOR = 5'h01;
    localparam logic [4:0] UOP_SUB = 5'h02;
    localparam logic [4:0] UOP_RSB = 5'h03;
    localparam logic [4:0] UOP_ADD = 5'h04;
    localparam logic [4:0] UOP_ADC = 5'h05;
    localparam logic [4:0] UOP_SBC = 5'h06;
    localparam logic [4:0] UOP_RSC = 5'h07;
    localparam logic [4:0] UOP_TST = 5'h08;
    localparam logic [4:0] UOP_TEQ = 5'h09;
    localparam logic [4:0] UOP_CMP = 5'h0A;
    localparam logic [4:0] UOP_CMN = 5'h0B;
    localparam logic [4:0] UOP_ORR = 5'h0C;
    localparam logic [4:0] UOP_MOV = 5'h0D;
    localparam logic [4:0] UOP_BIC = 5'h0E;
    localparam logic [4:0] UOP_MVN = 5'h0F;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
    // TST/TEQ/CMP/CMN occupy 01000..01011 and never write back
    function automatic logic is_compare(input logic [4:0] u);
        return u[4:2] == 3'b010;
    endfunction
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU producing result and next {Z,C,N,V} flags
module exec_alu #(
    parameter int W = exec_pkg::DATA_W
) (
    input  logic [W-1:0] lhs,
    input  logic [W-1:0] rhs,
    input  logic [4:0]   uop,
    input  logic         cin,
    input  logic [3:0]   flags_in,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    import exec_pkg::*;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lres;
    logic [W:0]   sum;
    logic         c0;
    logic         arith;
    // Map every arithmetic op onto a single adder: subtraction is a + ~b + 1
    always_comb begin
        a = lhs;
        b = rhs;
        c0 = 1'b0;
        arith = 1'b1;
        case (uop)
            UOP_SUB, UOP_CMP: begin b = ~rhs; c0 = 1'b1; end
            UOP_RSB:          begin a = rhs; b = ~lhs; c0 = 1'b1; end
            UOP_ADD, UOP_CMN: c0 = 1'b0;
            UOP_ADC:          c0 = cin;
            UOP_SBC:          begin b = ~rhs; c0 = cin; end
            UOP_RSC:          begin a = rhs; b = ~lhs; c0 = cin; end
            default:          arith = 1'b0;
        endcase
    end
    assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c0};
    // Logical and move results
    always_comb begin
        case (uop)
            UOP_AND, UOP_TST: lres = lhs & rhs;
            UOP_EOR, UOP_TEQ: lres = lhs ^ rhs;
            UOP_ORR:          lres = lhs | rhs;
            UOP_MOV:          lres = rhs;
            UOP_BIC:          lres = lhs & ~rhs;
            UOP_MVN:          lres = ~rhs;
            default:          lres = '0;
        endcase
    end
    assign result = uop[4] ? '0 : (arith ? sum[W-1:0] : lres);
    // Reserved uops keep flags; logical ops pass C/V through
    always_comb begin
        flags = flags_in;
        if (!uop[4]) begin
            flags[FLAG_Z] = result == '0;
            flags[FLAG_N] = result[W-1];
            if (arith) begin
                flags[FLAG_C] = sum[W];
                flags[FLAG_V] = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
        end
    end
endmodule

// File: rtl/execute_core.sv
// execute_core: register file, ALU, PC and flag register of the execute stage
// Optional: define EXECUTE_CORE_PC_R15_EN to make read index 15 return the PC
module execute_core #(
    parameter int DATA_W = exec_pkg::DATA_W,
    parameter int NREGS  = exec_pkg::NREGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_reg_enable,
    input  logic              wdata_sel,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [3:0]        sel_in,
    input  logic [3:0]        sel_p0,
    input  logic [3:0]        sel_p1,
    input  logic [4:0]        uop,
    input  logic              set_flags,
    input  logic              pc_we,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        alu_flags,
    output logic [3:0]        flags_out,
    output logic [DATA_W-1:0] pc_out
);
    import exec_pkg::*;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] pc;
    logic [3:0]        flags;
    logic [DATA_W-1:0] wdata;
`ifdef EXECUTE_CORE_PC_R15_EN
    assign p0 = (sel_p0 == 4'd15) ? pc : regs[sel_p0];
    assign p1 = (sel_p1 == 4'd15) ? pc : regs[sel_p1];
`else
    assign p0 = regs[sel_p0];
    assign p1 = regs[sel_p1];
`endif
    assign wdata     = wdata_sel ? ext_data : alu_out;
    assign flags_out = flags;
    assign pc_out    = pc;
    exec_alu #(.W(DATA_W)) u_alu (
        .lhs      (p0),
        .rhs      (p1),
        .uop      (uop),
        .cin      (flags[FLAG_C]),
        .flags_in (flags),
        .result   (alu_out),
        .flags    (alu_flags)
    );
    // Register write-back; compare ops only update flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (in_reg_enable && !is_compare(uop)) begin
            regs[sel_in] <= wdata;
        end
    end
    // Status flags commit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) flags <= '0;
        else if (set_flags) flags <= alu_flags;
    end
    // Program counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc <= '0;
        else if (pc_we) pc <= pc_in;
    end
endmodule

// File: tb/tb_execute_core.sv
// tb_execute_core: directed and random checks of execute_core against an arithmetic model
module tb_execute_core;
    import exec_pkg::*;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_reg_enable = 1'b0;
    logic        wdata_sel = 1'b0;
    logic        set_flags = 1'b0;
    logic        pc_we = 1'b0;
    logic [31:0] ext_data = '0;
    logic [31:0] pc_in = '0;
    logic [3:0]  sel_in = '0;
    logic [3:0]  sel_p0 = '0;
    logic [3:0]  sel_p1 = '0;
    logic [4:0]  uop = '0;
    logic [31:0] p0, p1, alu_out, pc_out;
    logic [3:0]  alu_flags, flags_out;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_regs [16];
    logic [31:0] m_pc;
    logic [3:0]  m_flags;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    execute_core dut (
        .clock(clock), .reset(reset), .in_reg_enable(in_reg_enable), .wdata_sel(wdata_sel),
        .ext_data(ext_data), .sel_in(sel_in), .sel_p0(sel_p0), .sel_p1(sel_p1), .uop(uop),
        .set_flags(set_flags), .pc_we(pc_we), .pc_in(pc_in), .p0(p0), .p1(p1),
        .alu_out(alu_out), .alu_flags(alu_flags), .flags_out(flags_out), .pc_out(pc_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] idx);
`ifdef EXECUTE_CORE_PC_R15_EN
        if (idx == 4'd15) return m_pc;
`endif
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pc = '0;
        m_flags = '0;
    endtask

    // Returns {result, Z, C, N, V} from signed/unsigned integer arithmetic
    function automatic logic [35:0] ref_alu(input logic [4:0] u, input logic [31:0] l,
                                            input logic [31:0] r, input logic [3:0] f);
        longint ul, ur, sl, sr, us, ss, nb;
        logic [31:0] res;
        logic c, v;
        bit add;
        ul = longint'(l); ur = longint'(r);
        sl = longint'($signed(l)); sr = longint'($signed(r));
        c = f[2]; v = f[0];
        nb = c ? 64'd0 : 64'd1;
        us = 0; ss = 0; add = 1'b1; res = '0;
        if (u[4]) return {32'h0, f};
        case (u[3:0])
            4'd2, 4'd10: begin us = ul - ur; ss = sl - sr; add = 1'b0; end
            4'd3:        begin us = ur - ul; ss = sr - sl; add = 1'b0; end
            4'd4, 4'd11: begin us = ul + ur; ss = sl + sr; end
            4'd5:        begin us = ul + ur + (1 - nb); ss = sl + sr + (1 - nb); end
            4'd6:        begin us = ul - ur - nb; ss = sl - sr - nb; add = 1'b0; end
            4'd7:        begin us = ur - ul - nb; ss = sr - sl - nb; add = 1'b0; end
            4'd0, 4'd8:  res = l & r;
            4'd1, 4'd9:  res = l ^ r;
            4'd12:       res = l | r;
            4'd13:       res = r;
            4'd14:       res = l & ~r;
            default:     res = ~r;
        endcase
        if (u[3:0] inside {[2:7], [10:11]}) begin
            res = us[31:0];
            c = add ? (us > 64'sh0000_0000_FFFF_FFFF) : (us >= 0);
            v = (ss > SMAX) || (ss < SMIN);
        end
        return {res, res == 32'h0, c, res[31], v};
    endfunction

    task automatic step(input logic we, input logic ws, input logic [31:0] ext, input logic [3:0] si,
                        input logic [3:0] s0, input logic [3:0] s1, input logic [4:0] u,
                        input logic sf, input logic pw, input logic [31:0] pcv);
        logic [35:0] exp;
        in_reg_enable = we; wdata_sel = ws; ext_data = ext; sel_in = si;
        sel_p0 = s0; sel_p1 = s1; uop = u; set_flags = sf; pc_we = pw; pc_in = pcv;
        #1;
        exp = ref_alu(u, model_rd(s0), model_rd(s1), m_flags);
        check("p0", p0, model_rd(s0));
        check("p1", p1, model_rd(s1));
        check("alu_out", alu_out, exp[35:4]);
        check("alu_flags", {28'h0, alu_flags}, {28'h0, exp[3:0]});
        @(posedge clock);
        if (we && !(u inside {[8:11]})) m_regs[si] = ws ? ext : exp[35:4];
        if (sf) m_flags = exp[3:0];
        if (pw) m_pc = pcv;
        #1;
        check("flags_out", {28'h0, flags_out}, {28'h0, m_flags});
        check("pc_out", pc_out, m_pc);
    endtask

    task automatic load(input logic [3:0] idx, input logic [31:0] val);
        step(1'b1, 1'b1, val, idx, 4'd0, 4'd0, UOP_AND, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic alu(input logic [4:0] u, input logic [3:0] d, input logic [3:0] a,
                       input logic [3:0] b, input logic sf);
        step(1'b1, 1'b0, 32'h0, d, a, b, u, sf, 1'b0, 32'h0);
    endtask

    task automatic peek(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        sel_p0 = idx;
        #1;
        check(tag, p0, exp);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_pc", pc_out, 32'h0);
        check("reset_flags", {28'h0, flags_out}, 32'h0);
        // asynchronous reset mid-run
        load(4'd0, 32'h2);
        step(1'b0, 1'b0, 32'h0, 4'd0, 4'd0, 4'd0, UOP_SUB, 1'b1, 1'b1, 32'h100);
        check("pre_reset_flags", {28'h0, flags_out}, 32'hC);
        sel_p0 = 4'd0;
        reset = 1'b1;
        #1;
        check("async_p0", p0, 32'h0);
        check("async_flags", {28'h0, flags_out}, 32'h0);
        check("async_pc", pc_out, 32'h0);
        model_reset();
        #1 reset = 1'b0;
        // SUB producing negative
        load(4'd0, 32'h2);
        load(4'd1, 32'h1);
        alu(UOP_SUB, 4'd2, 4'd1, 4'd0, 1'b1);
        check("sub_flags", {28'h0, flags_out}, 32'h2);
        peek("sub_r2", 4'd2, 32'hFFFF_FFFF);
        // ADD signed overflow
        load(4'd0, 32'h7FFF_FFFF);
        alu(UOP_ADD, 4'd3, 4'd0, 4'd1, 1'b1);
        check("add_flags", {28'h0, flags_out}, 32'h3);
        peek("add_r3", 4'd3, 32'h8000_0000);
        // CMP never writes back
        load(4'd4, 32'h5);
        load(4'd5, 32'h5);
        step(1'b1, 1'b0, 32'h0, 4'd4, 4'd4, 4'd5, UOP_CMP, 1'b1, 1'b0, 32'h0);
        check("cmp_flags", {28'h0, flags_out}, 32'hC);
        peek("cmp_r4", 4'd4, 32'h5);
        // ADC with carry in, SBC with carry clear
        load(4'd6, 32'hFFFF_FFFF);
        load(4'd7, 32'h0);
        alu(UOP_ADC, 4'd9, 4'd6, 4'd7, 1'b1);
        check("adc_flags", {28'h0, flags_out}, 32'hC);
        peek("adc_r9", 4'd9, 32'h0);
        load(4'd8, 32'h3);
        alu(UOP_CMP, 4'd0, 4'd1, 4'd0, 1'b1);
        check("cmp2_flags", {28'h0, flags_out}, 32'h2);
        alu(UOP_SBC, 4'd10, 4'd4, 4'd8, 1'b1);
        check("sbc_flags", {28'h0, flags_out}, 32'h4);
        peek("sbc_r10", 4'd10, 32'h1);
        // write disabled, logical C/V pass-through, reserved uop
        step(1'b0, 1'b0, 32'h0, 4'd4, 4'd4, 4'd5, UOP_ADD, 1'b0, 1'b0, 32'h0);
        peek("nowe_r4", 4'd4, 32'h5);
        load(4'd11, 32'h8000_0000);
        alu(UOP_ADD, 4'd12, 4'd11, 4'd11, 1'b1);
        check("cv_flags", {28'h0, flags_out}, 32'hD);
        load(4'd13, 32'hF0);
        load(4'd14, 32'h0F);
        alu(UOP_AND, 4'd15, 4'd13, 4'd14, 1'b1);
        check("and_flags", {28'h0, flags_out}, 32'hD);
        step(1'b1, 1'b0, 32'h0, 4'd1, 4'd13, 4'd14, 5'b10101, 1'b1, 1'b0, 32'h0);
        check("rsv_flags", {28'h0, flags_out}, 32'hD);
        peek("rsv_r1", 4'd1, 32'h0);
        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 5'($urandom_range(0, 19)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_core.md
Name: execute_core

Overview:
Execute-stage datapath: a 16-entry x 32-bit register file with two combinational read ports, a 5-bit-uop ALU fed by those ports, a write-back path, a PC register and a 4-bit status-flag register. Operands are selected by register index, the ALU computes combinationally, and result and flags are committed on the rising clock edge. Sits between decode (which supplies selects/uop/enables) and fetch (which consumes pc_out).

Parameters:
DATA_W, 32, datapath and register width; N is bit DATA_W-1.
NREGS, 16, register count; index width is 4 bits (fixed).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
in_reg_enable  in  1  register write enable
wdata_sel  in  1  write-data source: 0 = ALU result, 1 = ext_data
ext_data  in  DATA_W  external write data (loads)
sel_in  in  4  destination register index
sel_p0  in  4  read port 0 index (ALU LHS)
sel_p1  in  4  read port 1 index (ALU RHS)
uop  in  5  ALU micro-op
set_flags  in  1  flag-register write enable
pc_we  in  1  PC write enable
pc_in  in  DATA_W  next PC value
p0  out  DATA_W  register[sel_p0], combinational
p1  out  DATA_W  register[sel_p1], combinational
alu_out  out  DATA_W  ALU result, combinational
alu_flags  out  4  ALU next flags {Z,C,N,V}, combinational
flags_out  out  4  stored flags {Z,C,N,V} (bit3 Z, bit2 C, bit1 N, bit0 V)
pc_out  out  DATA_W  stored PC

Behaviour:
- Reset (async, active-high): all registers, PC and flags to 0; p0/p1/pc_out/flags_out read 0 immediately.
- Reads: asynchronous. Read-during-write returns the old value; the new value is visible after the edge. Both ports may select the same register.
- Write: at the rising edge, if in_reg_enable and the uop is not a compare op, reg[sel_in] <= (wdata_sel ? ext_data : alu_out).
- Flags: at the rising edge, if set_flags, flags <= alu_flags; otherwise they hold.
- PC: at the rising edge, if pc_we, PC <= pc_in.
- The register write, flag write and PC write are independent and may all occur in the same cycle.
- uop encoding (LHS=p0, RHS=p1, Cin=flags_out C):
  - 00000 AND
  - 00001 EOR
  - 00010 SUB L-R
  - 00011 RSB R-L
  - 00100 ADD
  - 00101 ADC L+R+Cin
  - 00110 SBC L-R-!Cin
  - 00111 RSC R-L-!Cin
  - 01000 TST (AND)
  - 01001 TEQ (EOR)
  - 01010 CMP (SUB)
  - 01011 CMN (ADD)
  - 01100 ORR
  - 01101 MOV R
  - 01110 BIC L&~R
  - 01111 MVN ~R
  - 1xxxx reserved: result 0, alu_flags = flags_out.
- Compare ops (TST, TEQ, CMP, CMN) never write the register file.
- Flags:
  - Z = result==0; N = result[N].
  - Arithmetic: C = carry-out of the DATA_W+1-bit sum; subtraction is computed as L+~R+1, so C = NOT borrow. V = signed overflow.
  - Logical/MOV/MVN: C and V are passed through from flags_out.

Optional Feature:
EXECUTE_CORE_PC_R15_EN: when defined, a read select of 15 on p0/p1 returns the PC (pc_out) instead of reg[15]; writes to index 15 still target reg[15]. When undefined, index 15 is an ordinary register.

Decomposition:
- Package exec_pkg: uop localparams (UOP_AND..UOP_MVN), flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0), DATA_W default.
- One sub-module, exec_alu: purely combinational (LHS, RHS, uop, cin, flags_in) -> (result, flags). The register file, PC and flag register stay in execute_core.

Test Plan:
1. Reset mid-run: write r0=0x2, then pulse reset between edges -> p0 (sel_p0=0)=0, flags_out=0000 and pc_out=0 immediately, with no clock edge.
2. ext_data r0=2, r1=1; then sel_p0=1, sel_p1=0, uop=SUB, sel_in=2, wdata_sel=0, set_flags=1 -> r2=0xFFFFFFFF, flags_out=0010.
3. r0=0x7FFFFFFF, r1=1, ADD into r3 with set_flags -> r3=0x80000000, flags_out=0011.
4. CMP r4=5 vs r5=5, in_reg_enable=1, sel_in=4 -> r4 stays 5, flags_out=1100.
5. With C=1: ADC 0xFFFFFFFF+0 -> result 0, flags 1100; SBC 5-3 with C=0 -> 1, C=1.
6. in_reg_enable=0, uop=ADD -> destination unchanged. AND 0xF0&0x0F with C=1, V=1 -> flags_out=1101 (Z=1, C/V preserved). uop=10101 -> alu_out=0, flags held.
